// File: rtl/cpu_gen.sv
// Multi-cycle accumulator CPU: fetch / argument / memory / write / output states over one shared memory port.
// Reads return data one cycle after mem_re; OUT holds out_valid/out_data until out_ready, then resumes fetching.
module cpu_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_c,
  output logic              flag_z
);

  typedef enum logic [3:0] {
    S_F0, S_F1, S_A0, S_A1, S_M0, S_M1, S_W, S_OUT, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [ADDR_W-1:0]   r_z, w_z_nxt;
  logic [3:0]          r_op, w_op_nxt;
  logic                r_c, w_c_nxt;
  logic                r_zf, w_zf_nxt;

  logic [ADDR_W-1:0]   w_arg;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0]   w_opnd;
  logic [DATA_W:0]     w_sum;

  // The memory operand (the B value) feeds the adder directly in M1, so no separate copy is stored.
  assign w_arg    = mem_rdata[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_opnd   = (r_op == OP_SUB) ? ~mem_rdata : mem_rdata;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_opnd} + (DATA_W+1)'(r_op == OP_SUB);

  assign mem_wdata = r_a;
  assign out_data  = r_a;
  assign halted    = (r_state == S_HALT);
  assign pc        = r_pc;
  assign flag_c    = r_c;
  assign flag_z    = r_zf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_F0;
      r_pc    <= '0;
      r_a     <= '0;
      r_z     <= '0;
      r_op    <= '0;
      r_c     <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_a     <= w_a_nxt;
      r_z     <= w_z_nxt;
      r_op    <= w_op_nxt;
      r_c     <= w_c_nxt;
      r_zf    <= w_zf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_a_nxt     = r_a;
    w_z_nxt     = r_z;
    w_op_nxt    = r_op;
    w_c_nxt     = r_c;
    w_zf_nxt    = r_zf;
    mem_addr    = r_pc;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    out_valid   = 1'b0;

    case (r_state)
      S_F0: begin
        mem_re      = 1'b1;
        w_state_nxt = S_F1;
      end
      S_F1: begin
        w_op_nxt = mem_rdata[3:0];
        w_pc_nxt = w_pc_inc;
        case (mem_rdata[3:0])
          OP_LDA, OP_ADD, OP_SUB, OP_STA,
          OP_LDI, OP_JMP, OP_JC, OP_JZ: w_state_nxt = S_A0;
          OP_OUT:                       w_state_nxt = S_OUT;
          OP_HLT:                       w_state_nxt = S_HALT;
          default:                      w_state_nxt = S_F0;
        endcase
      end
      S_A0: begin
        mem_re      = 1'b1;
        w_state_nxt = S_A1;
      end
      S_A1: begin
        w_z_nxt     = w_arg;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_F0;
        case (r_op)
          OP_JMP: w_pc_nxt = w_arg;
          OP_JC:  if (r_c)  w_pc_nxt = w_arg;
          OP_JZ:  if (r_zf) w_pc_nxt = w_arg;
          OP_LDI: begin
            w_a_nxt  = mem_rdata;
            w_zf_nxt = (mem_rdata == '0);
          end
          OP_LDA, OP_ADD, OP_SUB: w_state_nxt = S_M0;
          OP_STA:                 w_state_nxt = S_W;
          default:                w_state_nxt = S_F0;
        endcase
      end
      S_M0: begin
        mem_addr    = r_z;
        mem_re      = 1'b1;
        w_state_nxt = S_M1;
      end
      S_M1: begin
        if (r_op == OP_LDA) begin
          w_a_nxt  = mem_rdata;
          w_zf_nxt = (mem_rdata == '0);
        end else begin
          w_a_nxt  = w_sum[DATA_W-1:0];
          w_c_nxt  = w_sum[DATA_W];
          w_zf_nxt = (w_sum[DATA_W-1:0] == '0);
        end
        w_state_nxt = S_F0;
      end
      S_W: begin
        mem_addr    = r_z;
        mem_we      = 1'b1;
        w_state_nxt = S_F0;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_F0;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_F0;
    endcase

    // A reset cycle must never commit a write or offer output, whatever state it interrupts.
    if (reset) begin
      mem_we    = 1'b0;
      out_valid = 1'b0;
    end
  end

endmodule
